// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select, load-use stall and branch flush generator driven by an in-flight tag pipeline.
// Optional stall/flush performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module fwd_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   ex_branch_taken,
    output logic [1:0]             forwardA,
    output logic [1:0]             forwardB,
    output logic                   stall,
    output logic                   flush,
    output logic [STALL_CNT_W-1:0] cnt_stall,
    output logic [STALL_CNT_W-1:0] cnt_flush
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              mr;
    } slot_t;

    typedef struct packed {
        slot_t             tag;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
    } ex_slot_t;

    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_RF    = 2'b00;

    ex_slot_t   ex_q, ex_d;
    slot_t      mem_q, mem_d;
    slot_t      wb_q, wb_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    function automatic logic src_hit(input logic vld, input logic use_s,
                                     input logic [REG_AW-1:0] rs, input slot_t x);
        return vld && use_s && x.v && x.rw && (x.rd == rs);
    endfunction

    // The older slot only wins when the younger one does not hold the register.
    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
        if (hit_ex)
            return FWD_EXMEM;
        else if (hit_mem)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    logic hit_a_ex, hit_b_ex, hit_a_mem, hit_b_mem;
    logic bubble;

    always_comb begin
        hit_a_ex  = src_hit(id_valid, id_use_rs1, id_rs1, ex_q.tag);
        hit_b_ex  = src_hit(id_valid, id_use_rs2, id_rs2, ex_q.tag);
        hit_a_mem = src_hit(id_valid, id_use_rs1, id_rs1, mem_q);
        hit_b_mem = src_hit(id_valid, id_use_rs2, id_rs2, mem_q);

        flush  = ex_branch_taken;
        stall  = !flush && ex_q.tag.mr && (hit_a_ex || hit_b_ex);
        bubble = stall || flush;
    end

    always_comb begin
        wb_d  = mem_q;
        mem_d = ex_q.tag;

        ex_d             = '0;
        ex_d.tag.v       = id_valid && !bubble;
        ex_d.tag.rd      = id_rd;
        ex_d.tag.rw      = id_reg_write && (id_rd != '0);
        ex_d.tag.mr      = id_mem_read;
        ex_d.rs1         = id_rs1;
        ex_d.rs2         = id_rs2;
        ex_d.use_rs1     = id_use_rs1;
        ex_d.use_rs2     = id_use_rs2;
        if (bubble) ex_d = '0;

        fwd_a_d = bubble ? FWD_RF : fwd_sel(hit_a_ex, hit_a_mem);
        fwd_b_d = bubble ? FWD_RF : fwd_sel(hit_b_ex, hit_b_mem);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign forwardA = fwd_a_q;
    assign forwardB = fwd_b_q;

    // WB tag and EX source fields track the pipeline for debug visibility only.
    logic unused_tags;
    assign unused_tags = ^{wb_q, ex_q.rs1, ex_q.rs2, ex_q.use_rs1, ex_q.use_rs2};

`ifdef HAZARD_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] cnt_stall_q, cnt_stall_d;
    logic [STALL_CNT_W-1:0] cnt_flush_q, cnt_flush_d;

    always_comb begin
        cnt_stall_d = cnt_stall_q + STALL_CNT_W'(stall);
        cnt_flush_d = cnt_flush_q + STALL_CNT_W'(flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_stall_q <= '0;
            cnt_flush_q <= '0;
        end else begin
            cnt_stall_q <= cnt_stall_d;
            cnt_flush_q <= cnt_flush_d;
        end
    end

    assign cnt_stall = cnt_stall_q;
    assign cnt_flush = cnt_flush_q;
`else
    assign cnt_stall = '0;
    assign cnt_flush = '0;
`endif

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Producer side of the EX-stage forwarding interface: generates the 2-bit forwardA/forwardB select codes consumed by the EX stage operand muxes.
- Also generates load-use stall and branch flush controls for IF/ID/EX.
- Tracks the destination tags of in-flight instructions in an internal tag pipeline (EX, MEM, WB slots) that advances in lockstep with the datapath pipeline registers.
- Forward codes are registered on the ID->EX transfer, so they are valid for the entire EX cycle of the instruction they belong to.

Parameters:
- REG_AW, 5, register address width.
- STALL_CNT_W, 32, width of the optional performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- id_valid  input  1  ID holds a real instruction.
- id_rs1  input  REG_AW  ID source register 1.
- id_rs2  input  REG_AW  ID source register 2.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2; stores count.
- id_rd  input  REG_AW  ID destination register.
- id_reg_write  input  1  ID instruction writes rd.
- id_mem_read  input  1  ID instruction is a load.
- ex_branch_taken  input  1  EX resolved a taken branch or jump this cycle.
- forwardA  output  2  EX operand A select: 10 = EX/MEM ALU result, 01 = WB write data, 00 = register file.
- forwardB  output  2  EX operand B / store-data select, same encoding as forwardA.
- stall  output  1  load-use stall: hold PC and IF/ID, insert bubble into ID/EX.
- flush  output  1  squash IF/ID and ID/EX contents.
- cnt_stall  output  STALL_CNT_W  stall cycle count (optional feature only).
- cnt_flush  output  STALL_CNT_W  flush cycle count (optional feature only).

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous, active-high.
- Reset:
  - All tag slots are invalid.
  - forwardA = forwardB = 00; stall = 0; flush = 0; counters = 0.
- Tag slot contents: {v, rd, rw, mr}. The EX slot additionally holds the rs1/rs2 numbers and use bits of the instruction in EX.
- Slot write qualification: a slot's rw is stored as id_reg_write && id_rd != 0, so x0 never matches.
- Match condition, per source s of the ID instruction against slot X: id_valid && id_use_s && X.v && X.rw && X.rd == id_rs_s.
- stall (combinational):
  - Asserted when either ID source matches the EX slot and EX.mr = 1.
  - Forced to 0 when flush = 1.
- flush (combinational): flush = ex_branch_taken.
- Tag advance, every cycle when not in reset:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields, or an invalid bubble when stall or flush is asserted.
- Forward code registration, at the same edge:
  - The ID instruction's forward codes are computed against the pre-advance EX slot (which becomes MEM) and the pre-advance MEM slot (which becomes WB).
  - The result is registered into forwardA/forwardB.
- Forward priority: a match on the pre-advance EX slot gives 10 and overrides a match on the pre-advance MEM slot, which gives 01. No match gives 00.
- Bubble case: when stall or flush inserts a bubble, forwardA/forwardB are registered as 00.
- Load-use resolution: after a one-cycle stall, the load sits in the MEM slot. The re-presented ID instruction then gets 01 next cycle, i.e. WB-stage load data.
- Load-use latency: exactly one stall cycle per load-use dependency. Back-to-back dependent loads each stall once.
- WB-to-ID hazard: the register file is write-first, so a WB write and a same-cycle ID read need no third forwarding source.
- Simultaneous flush and stall: flush wins, stall is 0, EX becomes a bubble, and the MEM and WB slots still advance normally.
- rst asserted mid-operation: all slots are invalidated at that edge, and no stale forward code survives.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - cnt_stall increments on each cycle with stall = 1.
  - cnt_flush increments on each cycle with flush = 1.
  - Both wrap modulo 2^STALL_CNT_W.
  - Both are cleared by rst.
- Undefined: cnt_stall and cnt_flush are tied to 0 and no counter flops exist.

Test Plan:
1. Reset then idle: hold rst 2 cycles, then id_valid = 0 for 5 cycles -> forwardA = forwardB = 00, stall = 0, flush = 0 throughout.
2. EX/MEM forward: `add x5,x1,x2` then `sub x6,x5,x3` -> forwardA = 10 during the sub's EX cycle, forwardB = 00, no stall.
3. MEM/WB forward and priority:
   - `add x5`, nop, `or x7,x5,x5` -> forwardA = forwardB = 01.
   - `add x5`, `add x5`, `or x7,x5,x0` -> forwardA = 10 (youngest wins).
4. Load-use: `lw x8,0(x1)` then `add x9,x8,x2` -> stall = 1 for exactly 1 cycle, bubble into EX, then forwardA = 01 in the add's EX cycle.
5. x0 and flush:
   - `add x0,x1,x2` then `add x3,x0,x0` -> forward codes 00.
   - ex_branch_taken = 1 together with a load-use condition -> flush = 1, stall = 0, next-cycle forward codes 00.
6. Counters (HAZARD_PERF_CNT_EN defined): 3 load-use pairs plus 2 taken branches -> cnt_stall = 3, cnt_flush = 2; pulse rst -> both return to 0.
